writeback_stage: RTL and testbench

//  Final pipeline stage. Accepts retiring instructions from the memory stage and

---
 rtl/writeback_stage.sv | 187 ++++++++++++++++++
 tb/tb_writeback_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects ALU / load / link data, drives the register-file write
// port, holds upstream while a load waits for its response, and counts retirements.
module writeback_stage #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned LOAD_TIMEOUT = 16,
   // Reset value of retired_cnt (normally 0)
   parameter logic [31:0] CNT_RESET    = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_rf_wb,
   input  logic [1:0]      in_wb_src,
   input  logic [4:0]      in_rd,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_pc_plus_4,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wadr,
   output logic            we_wb,
   output logic            stall_wb,
   output logic            retire,
   output logic [31:0]     retired_cnt,
   output logic            misalign_err,
   output logic            timeout_err
);

   localparam int unsigned TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam logic [TW-1:0] TimerLast = TW'(LOAD_TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StWaitLoad} state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [4:0]        ld_rd_q, ld_rd_d;
   logic [2:0]        ld_funct3_q, ld_funct3_d;
   logic [1:0]        ld_addr_q, ld_addr_d;
   logic              ld_rf_wb_q, ld_rf_wb_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic [4:0]        wadr_q, wadr_d;
   logic              we_q, we_d;
   logic              retire_q, retire_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              mis_q, mis_d;
   logic              to_q, to_d;
   logic              transfer;

   function automatic logic [XLEN-1:0] align_load(input logic [2:0] f3,
                                                  input logic [1:0] a,
                                                  input logic [XLEN-1:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[8*a +: 8];
      h = d[16*a[1] +: 16];
      case (f3)
         3'b000:  align_load = {{(XLEN-8){b[7]}}, b};
         3'b001:  align_load = {{(XLEN-16){h[15]}}, h};
         3'b100:  align_load = {{(XLEN-8){1'b0}}, b};
         3'b101:  align_load = {{(XLEN-16){1'b0}}, h};
         default: align_load = d;
      endcase
   endfunction

   // Illegal load encodings are reported through the same misalign path.
   function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b000, 3'b100: load_misaligned = 1'b0;
         3'b001, 3'b101: load_misaligned = a[0];
         3'b010:         load_misaligned = (a != 2'b00);
         default:        load_misaligned = 1'b1;
      endcase
   endfunction

   assign in_ready = (state_q == StIdle);
   assign transfer = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      ld_rd_d     = ld_rd_q;
      ld_funct3_d = ld_funct3_q;
      ld_addr_d   = ld_addr_q;
      ld_rf_wb_d  = ld_rf_wb_q;
      wb_data_d   = wb_data_q;
      wadr_d      = wadr_q;
      we_d        = 1'b0;
      retire_d    = 1'b0;
      mis_d       = 1'b0;
      to_d        = 1'b0;
      cnt_d       = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (transfer) begin
               if (in_wb_src == 2'b10) begin
                  if (load_misaligned(in_funct3, in_alu_result[1:0])) begin
                     mis_d    = 1'b1;
                     retire_d = 1'b1;
                  end else if (mem_rsp_valid) begin
                     wb_data_d = align_load(in_funct3, in_alu_result[1:0], mem_rsp_data);
                     wadr_d    = in_rd;
                     we_d      = in_rf_wb & (in_rd != 5'd0);
                     retire_d  = 1'b1;
                  end else begin
                     ld_rd_d     = in_rd;
                     ld_funct3_d = in_funct3;
                     ld_addr_d   = in_alu_result[1:0];
                     ld_rf_wb_d  = in_rf_wb;
                     timer_d     = '0;
                     state_d     = StWaitLoad;
                  end
               end else begin
                  wb_data_d = (in_wb_src == 2'b00) ? in_pc_plus_4 : in_alu_result;
                  wadr_d    = in_rd;
                  we_d      = in_rf_wb & (in_rd != 5'd0);
                  retire_d  = 1'b1;
               end
            end
         end
         StWaitLoad: begin
            // A response on the last allowed cycle beats the timeout.
            if (mem_rsp_valid) begin
               wb_data_d = align_load(ld_funct3_q, ld_addr_q, mem_rsp_data);
               wadr_d    = ld_rd_q;
               we_d      = ld_rf_wb_q & (ld_rd_q != 5'd0);
               retire_d  = 1'b1;
               state_d   = StIdle;
            end else if (timer_q == TimerLast) begin
               to_d    = 1'b1;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (retire_d) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         ld_rd_q     <= '0;
         ld_funct3_q <= '0;
         ld_addr_q   <= '0;
         ld_rf_wb_q  <= 1'b0;
         wb_data_q   <= '0;
         wadr_q      <= '0;
         we_q        <= 1'b0;
         retire_q    <= 1'b0;
         cnt_q       <= CNT_RESET;
         mis_q       <= 1'b0;
         to_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         ld_rd_q     <= ld_rd_d;
         ld_funct3_q <= ld_funct3_d;
         ld_addr_q   <= ld_addr_d;
         ld_rf_wb_q  <= ld_rf_wb_d;
         wb_data_q   <= wb_data_d;
         wadr_q      <= wadr_d;
         we_q        <= we_d;
         retire_q    <= retire_d;
         cnt_q       <= cnt_d;
         mis_q       <= mis_d;
         to_q        <= to_d;
      end
   end

   assign stall_wb     = ~in_ready;
   assign wb_data      = wb_data_q;
   assign wadr         = wadr_q;
   assign we_wb        = we_q;
   assign retire       = retire_q;
   assign retired_cnt  = cnt_q;
   assign misalign_err = mis_q;
   assign timeout_err  = to_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized self-checking bench for writeback_stage against a behavioural model of
// the load alignment, misalignment, timeout and retire-count rules.
module tb_writeback_stage;

   localparam int unsigned T = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_rf_wb, mem_rsp_valid;
   logic [1:0]  in_wb_src;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu_result, in_pc_plus_4, mem_rsp_data;
   logic        in_ready, we_wb, stall_wb, retire, misalign_err, timeout_err;
   logic [31:0] wb_data, retired_cnt;
   logic [4:0]  wadr;
   logic        w_in_ready, w_we_wb, w_stall_wb, w_retire, w_misalign_err, w_timeout_err;
   logic [31:0] w_wb_data, w_retired_cnt;
   logic [4:0]  w_wadr;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] exp_cnt  = 32'd0;

   always #5 clk = ~clk;

   writeback_stage #(.XLEN(32), .LOAD_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rf_wb(in_rf_wb),
      .in_wb_src(in_wb_src), .in_rd(in_rd), .in_funct3(in_funct3),
      .in_alu_result(in_alu_result), .in_pc_plus_4(in_pc_plus_4),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .wb_data(wb_data),
      .wadr(wadr), .we_wb(we_wb), .stall_wb(stall_wb), .retire(retire),
      .retired_cnt(retired_cnt), .misalign_err(misalign_err), .timeout_err(timeout_err)
   );

   // Second instance with a preset counter, fed the same stimulus, to see the wrap.
   writeback_stage #(.XLEN(32), .LOAD_TIMEOUT(T), .CNT_RESET(32'hFFFF_FFFF)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_rf_wb(in_rf_wb),
      .in_wb_src(in_wb_src), .in_rd(in_rd), .in_funct3(in_funct3),
      .in_alu_result(in_alu_result), .in_pc_plus_4(in_pc_plus_4),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .wb_data(w_wb_data),
      .wadr(w_wadr), .we_wb(w_we_wb), .stall_wb(w_stall_wb), .retire(w_retire),
      .retired_cnt(w_retired_cnt), .misalign_err(w_misalign_err),
      .timeout_err(w_timeout_err)
   );

   typedef struct packed {
      logic        rdy;
      logic        stall;
      logic        we;
      logic        ret;
      logic        mis;
      logic        to;
      logic [4:0]  wadr;
      logic [31:0] data;
      logic [31:0] cnt;
   } out_t;

   function automatic out_t act_m(input bit keep);
      out_t o;
      o = '{in_ready, stall_wb, we_wb, retire, misalign_err, timeout_err, wadr, wb_data,
            retired_cnt};
      if (!keep) begin
         o.wadr = '0;
         o.data = '0;
      end
      return o;
   endfunction

   function automatic out_t expo(input logic rdy, input logic we, input logic ret,
                                 input logic mis, input logic to, input logic [4:0] a,
                                 input logic [31:0] d, input bit keep);
      out_t e;
      e = '{rdy, ~rdy, we, ret, mis, to, a, d, exp_cnt};
      if (!keep) begin
         e.wadr = '0;
         e.data = '0;
      end
      return e;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] d);
      logic [31:0] b, h;
      b = (d >> (8 * a)) & 32'hFF;
      h = (d >> (16 * (a / 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return d;
      endcase
   endfunction

   function automatic bit ref_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b000, 3'b100: return 1'b0;
         3'b001, 3'b101: return (a % 2) != 0;
         3'b010:         return a != 0;
         default:        return 1'b1;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic rf, input logic [1:0] src,
                        input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic rv, input logic [31:0] rdata);
      in_valid      = v;
      in_rf_wb      = rf;
      in_wb_src     = src;
      in_rd         = rd;
      in_funct3     = f3;
      in_alu_result = alu;
      in_pc_plus_4  = pc4;
      mem_rsp_valid = rv;
      mem_rsp_data  = rdata;
   endtask

   task automatic test_reset();
      out_t e;
      rst = 1'b0;
      drive(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      step();
      step();
      exp_cnt = 32'd0;
      e = expo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      n_checks++;
      if (act_m(1'b1) !== e) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", act_m(1'b1), e);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_alu();
      out_t e;
      drive(1'b1, 1'b1, 2'b01, 5'd5, 3'd0, 32'h1234, 32'h8000, 1'b0, 32'd0);
      step();
      drive(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      exp_cnt++;
      e = expo(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b1);
      n_checks++;
      if (act_m(1'b1) !== e) begin
         n_fail++;
         $display("FAIL alu_write: got %h want %h", act_m(1'b1), e);
      end
      step();
      e = expo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      n_checks++;
      if (act_m(1'b0) !== e) begin
         n_fail++;
         $display("FAIL alu_pulse_end: got %h want %h", act_m(1'b0), e);
      end
   endtask

   task automatic test_jal();
      out_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 2'b00, (i == 0) ? 5'd1 : 5'd0, 3'd0, $urandom, 32'h104, 1'b0,
               32'd0);
         step();
         drive(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
         exp_cnt++;
         e = expo(1'b1, i == 0, 1'b1, 1'b0, 1'b0, (i == 0) ? 5'd1 : 5'd0, 32'h104, 1'b1);
         n_checks++;
         if (act_m(1'b1) !== e) begin
            n_fail++;
            $display("FAIL jal_rd%0d: got %h want %h", (i == 0) ? 1 : 0, act_m(1'b1), e);
         end
      end
   endtask

   task automatic test_back_to_back();
      out_t        e;
      logic [1:0]  src;
      logic [4:0]  rd;
      logic        rf;
      logic [31:0] alu, pc4;
      for (int i = 0; i < 24; i++) begin
         src = (i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b01 : 2'b11);
         rd  = 5'($urandom);
         rf  = 1'($urandom);
         alu = $urandom;
         pc4 = $urandom;
         drive(1'b1, rf, src, rd, 3'($urandom), alu, pc4, 1'($urandom), $urandom);
         step();
         exp_cnt++;
         e = expo(1'b1, rf && (rd != 0), 1'b1, 1'b0, 1'b0, rd, (src == 2'b00) ? pc4 : alu,
                  1'b1);
         n_checks++;
         if (act_m(1'b1) !== e) begin
            n_fail++;
            $display("FAIL b2b_%0d: got %h want %h", i, act_m(1'b1), e);
         end
      end
      drive(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic test_loads();
      out_t        e;
      bit          ld;
      logic [2:0]  f3;
      logic [31:0] addr, data, pc4;
      logic [1:0]  src;
      logic [4:0]  rd;
      logic        rf;
      int          d;
      for (int i = 0; i < 160; i++) begin
         ld   = 1'($urandom);
         f3   = 3'($urandom);
         addr = $urandom;
         d    = int'($urandom_range(0, T + 2));
         data = $urandom;
         pc4  = $urandom;
         rd   = 5'($urandom);
         rf   = 1'($urandom);
         case (i)
            0: begin ld = 1; f3 = 3'b000; addr = 32'h1003; d = 3; data = 32'h80FF_FFFF; end
            1: begin ld = 1; f3 = 3'b100; addr = 32'h1003; d = 3; data = 32'h80FF_FFFF; end
            2: begin ld = 1; f3 = 3'b101; addr = 32'h2002; d = 2; data = 32'hBEEF_0000; end
            3: begin ld = 1; f3 = 3'b010; addr = 32'h2002; d = 1; end
            4: begin ld = 1; f3 = 3'b010; addr = 32'h3000; d = T + 1; end
            5: begin ld = 1; f3 = 3'b010; addr = 32'h3004; d = T; data = 32'hCAFE_F00D; end
            6: begin ld = 1; f3 = 3'b001; addr = 32'h0000; d = 0; data = 32'h0000_8001; end
            default: ;
         endcase
         if (i < 7) begin
            rd = 5'(7 + i);
            rf = 1'b1;
         end
         src = ld ? 2'b10 : ((i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b01 : 2'b11));
         drive(1'b1, rf, src, rd, f3, addr, pc4, ld ? (d == 0) : 1'($urandom), data);
         step();
         drive(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
         if (!ld) begin
            exp_cnt++;
            e = expo(1'b1, rf && (rd != 0), 1'b1, 1'b0, 1'b0, rd,
                     (src == 2'b00) ? pc4 : addr, 1'b1);
         end else if (ref_misaligned(f3, addr[1:0])) begin
            exp_cnt++;
            e = expo(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
         end else begin
            if (d != 0) begin
               for (int k = 0; k < T; k++) begin
                  e = expo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
                  n_checks++;
                  if (act_m(1'b0) !== e) begin
                     n_fail++;
                     $display("FAIL load_wait_%0d_c%0d: got %h want %h", i, k, act_m(1'b0), e);
                  end
                  mem_rsp_valid = (k == d - 1);
                  mem_rsp_data  = data;
                  step();
                  mem_rsp_valid = 1'b0;
                  if (k == d - 1) break;
               end
            end
            if (d <= T) begin
               exp_cnt++;
               e = expo(1'b1, rf && (rd != 0), 1'b1, 1'b0, 1'b0, rd,
                        ref_load(f3, addr[1:0], data), 1'b1);
            end else begin
               e = expo(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 1'b0);
            end
         end
         n_checks++;
         if (act_m(e.we || (e.ret && !e.mis)) !== e) begin
            n_fail++;
            $display("FAIL load_txn_%0d: got %h want %h", i, act_m(e.we || (e.ret && !e.mis)),
                     e);
         end
         if ($urandom_range(0, 2) == 0) begin
            mem_rsp_valid = 1'($urandom);
            mem_rsp_data  = $urandom;
            step();
            mem_rsp_valid = 1'b0;
            e = expo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            n_checks++;
            if (act_m(1'b0) !== e) begin
               n_fail++;
               $display("FAIL idle_after_%0d: got %h want %h", i, act_m(1'b0), e);
            end
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      out_t e;
      drive(1'b1, 1'b1, 2'b10, 5'd3, 3'b010, 32'h40, 32'd0, 1'b0, 32'd0);
      step();
      drive(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      step();
      #2 rst = 1'b0;
      #1;
      exp_cnt = 32'd0;
      e = expo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      n_checks++;
      if (act_m(1'b1) !== e) begin
         n_fail++;
         $display("FAIL async_reset_wait: got %h want %h", act_m(1'b1), e);
      end
      @(negedge clk);
      rst = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h1111_2222;
      step();
      mem_rsp_valid = 1'b0;
      e = expo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      n_checks++;
      if (act_m(1'b0) !== e) begin
         n_fail++;
         $display("FAIL dropped_load: got %h want %h", act_m(1'b0), e);
      end
   endtask

   task automatic test_wrap();
      n_checks++;
      if (w_retired_cnt !== exp_cnt - 32'd1) begin
         n_fail++;
         $display("FAIL wrap_preset: got %h want %h", w_retired_cnt, exp_cnt - 32'd1);
      end
      drive(1'b1, 1'b1, 2'b01, 5'd9, 3'd0, 32'h55, 32'd0, 1'b0, 32'd0);
      step();
      drive(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      exp_cnt++;
      n_checks++;
      if (w_retired_cnt !== exp_cnt - 32'd1 || w_retire !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_to_zero: got cnt %h retire %b want cnt %h retire 1",
                  w_retired_cnt, w_retire, exp_cnt - 32'd1);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_jal();
      test_back_to_back();
      test_loads();
      test_reset_mid_wait();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
